// File: rtl/uart_dl_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_dl_ctrl
// Purpose : UART firmware-download controller. While the download enable is
//           high it holds the CPU halted. It parses framed program images from
//           the UART receive byte stream and writes them as 32-bit words into
//           instruction memory. After each frame it answers with ACK or NAK.
//           Frame layout:
//             SYNC, ADDR[7:0..31:24], LEN (words), LEN*4 data bytes, CSUM
// Ports   : clk_i/rst_ni          clock, async active-low reset
//           dl_en_i               raw download-enable pin (2-flop synchronized)
//           rx_data_i/rx_valid_i  received byte stream (1-cycle strobes)
//           tx_data_o/tx_valid_o/tx_ready_i  response byte handshake
//           mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_gnt_i
//                                 write-only bus master, req held until gnt
//           halt_req_o            CPU halt request
//           busy_o                frame open or write/response pending
// Revision: 1.0 - initial release
// ============================================================================
module uart_dl_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dl_en_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    output logic        halt_req_o,
    output logic        busy_o
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  ACK_BYTE = 8'h06;
    localparam logic [7:0]  NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RESP = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic [31:0] addr_q, addr_d;        // address shift register, then next word address
    logic [23:0] word_q, word_d;        // first three bytes of the word being assembled
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        dl_en;
    logic        frame_open;
    logic        tmo_hit;
    logic [31:0] word_full;
    logic        err_final;
    logic        buf_free;

    assign dl_en      = sync_q[1];
    assign frame_open = (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit    = frame_open && !rx_valid_i && (tmo_q == TMO_LAST);
    assign word_full  = {rx_data_i, word_q};
    assign err_final  = err_q | (rx_data_i != csum_q);
    // The write buffer is free now or becomes free at the end of this cycle.
    assign buf_free   = !mem_req_q || mem_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b00;
            addr_q      <= '0;
            word_q      <= '0;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
            csum_q      <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], dl_en_i};
            addr_q      <= addr_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            wcnt_q      <= wcnt_d;
            csum_q      <= csum_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        wcnt_d      = wcnt_q;
        csum_d      = csum_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        // Write handshake runs independently of the frame parser so that an
        // aborted frame still completes its outstanding write.
        if (mem_req_q && mem_gnt_i) begin
            mem_req_d = 1'b0;
        end

        if (rx_valid_i || !frame_open) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (!dl_en && (state_q != S_IDLE) && !(state_q == S_RESP && tx_valid_q)) begin
            // Abort: drop the frame silently; a response already on the
            // wire is allowed to finish in RESP.
            state_d = S_IDLE;
        end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = S_RESP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i && dl_en && (rx_data_i == SYNC_BYTE)) begin
                        state_d = S_ADDR;
                        csum_d  = '0;
                        err_d   = 1'b0;
                        bcnt_d  = '0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        csum_d = csum_q ^ rx_data_i;
                        addr_d = {rx_data_i, addr_q[31:8]};
                        bcnt_d = bcnt_q + 2'd1;
                        // First byte carries the alignment bits.
                        if ((bcnt_q == 2'd0) && (rx_data_i[1:0] != 2'b00)) begin
                            err_d = 1'b1;
                        end
                        if (bcnt_q == 2'd3) begin
                            state_d = S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (rx_valid_i) begin
                        csum_d = csum_q ^ rx_data_i;
                        bcnt_d = '0;
                        if (rx_data_i == 8'd0) begin
                            err_d   = 1'b1;
                            state_d = S_CSUM;
                        end else begin
                            wcnt_d  = rx_data_i;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        csum_d = csum_q ^ rx_data_i;
                        word_d = {rx_data_i, word_q[23:8]};
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            if (!err_q) begin
                                if (!buf_free) begin
                                    // Buffer still occupied: drop the word and
                                    // suppress the rest of the frame.
                                    err_d = 1'b1;
                                end else begin
                                    mem_req_d   = 1'b1;
                                    mem_addr_d  = addr_q;
                                    mem_wdata_d = word_full;
                                end
                            end
                            addr_d = addr_q + 32'd4;
                            wcnt_d = wcnt_q - 8'd1;
                            if (wcnt_q == 8'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid_i) begin
                        err_d   = err_final;
                        state_d = S_RESP;
                        if (buf_free) begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = err_final ? NAK_BYTE : ACK_BYTE;
                        end
                    end
                end
                S_RESP: begin
                    if (tx_valid_q) begin
                        if (tx_ready_i) begin
                            tx_valid_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end else if (buf_free) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = err_q ? NAK_BYTE : ACK_BYTE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE) || mem_req_q || tx_valid_q;
    assign halt_req_o  = dl_en | busy_o;

endmodule
`default_nettype wire

// File: tb/tb_uart_dl_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_dl_ctrl
// Purpose : Scoreboard bench for uart_dl_ctrl. Stimulus pushes expected memory
//           writes and response bytes into queues; a monitor pops and compares
//           whenever the DUT completes a write or response handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_dl_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dl_en = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic        mem_gnt = 1'b1;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        halt_req_o;
    logic        busy_o;

    always #5 clk = ~clk;

    uart_dl_ctrl #(
        .TIMEOUT_CYC (50),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .dl_en_i     (dl_en),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt),
        .halt_req_o  (halt_req_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned tx_cyc = 0;
    logic [64:0] exp_wr[$];   // {we, addr, data}
    logic [7:0]  exp_tx[$];
    logic [64:0] e_wr;
    logic [7:0]  e_tx;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && mem_req_o && mem_gnt) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h, required no write", mem_addr_o, mem_wdata_o);
            end else begin
                e_wr = exp_wr.pop_front();
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== e_wr) begin
                    errors++;
                    $display("FAIL wr_data: got we %b addr %h data %h, required we %b addr %h data %h",
                             mem_we_o, mem_addr_o, mem_wdata_o, e_wr[64], e_wr[63:32], e_wr[31:0]);
                end
            end
        end
        if (rst_n && tx_valid_o && tx_ready) begin
            checks++;
            tx_cyc = cyc;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h, required no response", tx_data_o);
            end else begin
                e_tx = exp_tx.pop_front();
                if (tx_data_o !== e_tx) begin
                    errors++;
                    $display("FAIL tx_data: got %h, required %h", tx_data_o, e_tx);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int period);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tick(period - 1);
    endtask

    // Sends the first nsend bytes of a frame (nsend < 0: whole frame).
    task automatic send_frame(input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [7:0] flip, input int period, input int nsend);
        logic [7:0]  q[$];
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            q.push_back(addr[8*i +: 8]);
            cs ^= addr[8*i +: 8];
        end
        q.push_back(len);
        cs ^= len;
        for (int k = 0; k < int'(len); k++) begin
            w = (k == 0) ? w0 : w1;
            for (int i = 0; i < 4; i++) begin
                q.push_back(w[8*i +: 8]);
                cs ^= w[8*i +: 8];
            end
        end
        q.push_back(cs ^ flip);
        for (int i = 0; i < q.size(); i++) begin
            if (nsend >= 0 && i >= nsend) break;
            send_byte(q[i], period);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0 || busy_o) && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: drain timed out with %0d writes and %0d responses outstanding, required 0",
                     name, exp_wr.size(), exp_tx.size());
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_o && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_req: mem_req_o got 0 after 1000 cycles, required 1");
        end
    endtask

    task automatic gnt_after_20();
        wait_req();
        tick(20);
        mem_gnt = 1'b1;
        tick(1);
        mem_gnt = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned t_last;
        bit          halt_dropped;

        tick(3);
        chk("rst_outputs_in_reset", {tx_data_o, tx_valid_o, mem_req_o, mem_we_o, halt_req_o, busy_o}, 64'h0);
        rst_n = 1'b1;
        tick(2);
        chk("rst_outputs", {tx_data_o, tx_valid_o, mem_req_o, mem_we_o, halt_req_o, busy_o}, 64'h0);
        chk("rst_addr_data", {mem_addr_o, mem_wdata_o}, 64'h0);

        // Enable takes two synchronizer stages to reach halt_req_o.
        dl_en = 1'b1;
        tick(1);
        chk("sync_stage1_halt", {63'h0, halt_req_o}, 64'h0);
        tick(1);
        chk("sync_stage2_halt", {63'h0, halt_req_o}, 64'h1);

        // Good frame, grant tied high.
        exp_wr.push_back({1'b1, 32'h0000_0100, 32'h1122_3344});
        exp_wr.push_back({1'b1, 32'h0000_0104, 32'hDEAD_BEEF});
        exp_tx.push_back(8'h06);
        send_frame(32'h0000_0100, 8'd2, 32'h1122_3344, 32'hDEAD_BEEF, 8'h00, 2, -1);
        drain("good_frame");

        // Bad checksum: writes go out, NAK returned.
        exp_wr.push_back({1'b1, 32'h0000_0100, 32'h1122_3344});
        exp_wr.push_back({1'b1, 32'h0000_0104, 32'hDEAD_BEEF});
        exp_tx.push_back(8'h15);
        send_frame(32'h0000_0100, 8'd2, 32'h1122_3344, 32'hDEAD_BEEF, 8'h01, 1, -1);
        drain("bad_csum");

        // Misaligned address: no writes at all.
        exp_tx.push_back(8'h15);
        send_frame(32'h0000_0102, 8'd2, 32'h1122_3344, 32'hDEAD_BEEF, 8'h00, 1, -1);
        drain("misaligned");

        // LEN = 0.
        exp_tx.push_back(8'h15);
        send_frame(32'h0000_0200, 8'd0, 32'h0, 32'h0, 8'h00, 1, -1);
        drain("len_zero");

        // Grant held off 20 cycles, bytes every 4 cycles: second word dropped.
        mem_gnt = 1'b0;
        exp_wr.push_back({1'b1, 32'h0000_0300, 32'hCAFE_F00D});
        exp_tx.push_back(8'h15);
        fork
            send_frame(32'h0000_0300, 8'd2, 32'hCAFE_F00D, 32'h0BAD_CAFE, 8'h00, 4, -1);
            begin
                wait_req();
                tick(20);
                mem_gnt = 1'b1;
            end
        join
        drain("overrun");

        // Same grant delay but bytes every 40 cycles: both writes land.
        mem_gnt = 1'b0;
        exp_wr.push_back({1'b1, 32'h0000_0400, 32'hCAFE_F00D});
        exp_wr.push_back({1'b1, 32'h0000_0404, 32'h0BAD_CAFE});
        exp_tx.push_back(8'h06);
        fork
            send_frame(32'h0000_0400, 8'd2, 32'hCAFE_F00D, 32'h0BAD_CAFE, 8'h00, 40, -1);
            begin
                gnt_after_20();
                gnt_after_20();
            end
        join
        mem_gnt = 1'b1;
        drain("slow_stream");

        // Timeout mid-DATA: 3 of 8 data bytes then silence.
        exp_tx.push_back(8'h15);
        send_frame(32'h0000_0500, 8'd2, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1, 9);
        t_last = cyc;
        drain("timeout");
        checks++;
        if ((tx_cyc - t_last) < 50 || (tx_cyc - t_last) > 53) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, required 50..53", tx_cyc - t_last);
        end

        // Abort mid-frame with a write pending: no response, write completes.
        mem_gnt = 1'b0;
        send_frame(32'h0000_0600, 8'd2, 32'hA1B2_C3D4, 32'h0, 8'h00, 1, 10);
        tick(2);
        chk("abort_req_pending", {63'h0, mem_req_o}, 64'h1);
        dl_en = 1'b0;
        tick(6);
        chk("abort_halt_held", {63'h0, halt_req_o}, 64'h1);
        exp_wr.push_back({1'b1, 32'h0000_0600, 32'hA1B2_C3D4});
        mem_gnt = 1'b1;
        halt_dropped = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (!halt_req_o) halt_dropped = 1'b1;
        end
        chk("abort_halt_released", {63'h0, halt_dropped}, 64'h1);
        tick(5);
        chk("abort_no_tx", {63'h0, busy_o, tx_valid_o}, 64'h0);
        chk("abort_write_done", 64'(exp_wr.size()), 64'h0);
        dl_en = 1'b1;
        tick(3);

        // Asynchronous reset mid-DATA with mem_req_o high.
        mem_gnt = 1'b0;
        send_frame(32'h0000_0700, 8'd2, 32'h5555_AAAA, 32'h0, 8'h00, 1, 10);
        tick(2);
        chk("pre_reset_req", {63'h0, mem_req_o}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {tx_data_o, tx_valid_o, mem_req_o, mem_we_o, halt_req_o, busy_o}, 64'h0);
        chk("async_reset_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        tick(4);
        exp_wr.push_back({1'b1, 32'h0000_0800, 32'h0102_0304});
        exp_tx.push_back(8'h06);
        send_frame(32'h0000_0800, 8'd1, 32'h0102_0304, 32'h0, 8'h00, 1, -1);
        drain("after_reset");

        chk("queues_empty", 64'(exp_wr.size() + exp_tx.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got no completion, required completion before 500us");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_dl_ctrl.md
# uart_dl_ctrl

UART firmware-download controller for the tinyriscv SoC. While the download-enable pin is high it holds the CPU halted, parses framed program images arriving on the UART receive byte stream, and writes them as 32-bit words into instruction memory through a bus-master port. After each frame it returns a one-byte ACK or NAK on the UART transmit stream.

## Interface
- TIMEOUT_CYC, 100000, inter-byte timeout in clk_i cycles while a frame is open
- SYNC_BYTE, 8'hA5, frame start marker
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- dl_en_i  input  1  raw uart_debug_pin; synchronized internally by 2 flops
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  one-cycle strobe per received byte
- tx_data_o  output  8  response byte
- tx_valid_o  output  1  response valid; held until tx_ready_i
- tx_ready_i  input  1  UART transmitter accepts byte
- mem_req_o  output  1  write request; held until mem_gnt_i
- mem_we_o  output  1  equals mem_req_o (write-only master)
- mem_addr_o  output  32  word address of write
- mem_wdata_o  output  32  write data
- mem_gnt_i  input  1  write accepted in the cycle mem_req_o & mem_gnt_i
- halt_req_o  output  1  CPU halt request
- busy_o  output  1  frame open or write/response pending

## Operation
- Frame: SYNC_BYTE, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], LEN (words, 1..255), LEN×4 data bytes little-endian per word, CSUM. CSUM = XOR of all bytes after SYNC_BYTE excluding CSUM.
- States: IDLE, ADDR, LEN, DATA, CSUM, RESP.
- IDLE: bytes other than SYNC_BYTE are ignored; SYNC_BYTE -> ADDR, clear checksum accumulator and error flag.
- ADDR: four bytes -> LEN. ADDR[1:0] != 0 sets the error flag.
- LEN: LEN == 0 sets error and goes directly to CSUM; otherwise -> DATA with word counter = LEN.
- DATA: every 4th byte completes a word. If there is no error, the word is loaded into the write buffer, and mem_addr_o = ADDR + 4×index. After the last word -> CSUM. When the error flag is set, bytes are consumed but no writes are issued.
- One-word write buffer. If a word completes while mem_req_o is still pending, the word is dropped, the error flag is set, and writes for the remainder of the frame are suppressed.
- CSUM: on receipt, a mismatch sets the error flag -> RESP.
- RESP: waits until mem_req_o is low, then presents tx_data_o = 8'h06 (ACK, no error) or 8'h15 (NAK) and holds tx_valid_o until tx_ready_i -> IDLE.
- Writes already granted before an error are not rolled back; the host retransmits the frame.
- Timeout: a counter resets on each rx_valid_i. Reaching TIMEOUT_CYC in ADDR/LEN/DATA/CSUM sets error -> RESP (NAK).
- dl_en deasserted (synchronized) outside IDLE: the frame is aborted and any pending write completes its handshake. Then -> IDLE with no response. A pending tx_valid_o is still completed.
- halt_req_o = synchronized dl_en | busy_o.
- Checksum/address arithmetic is 8-bit XOR and 32-bit add, both wrapping.

## Timing
- Reset values: tx_data_o 8'h00, tx_valid_o 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, halt_req_o 0, busy_o 0, state IDLE.
- dl_en_i to internal enable: 2 cycles.
- mem_req_o rises 1 cycle after the rx_valid_i of a word's 4th byte. It falls the cycle after the mem_req_o & mem_gnt_i cycle, and address/data are stable while req is high.
- The CSUM byte received with no write pending -> tx_valid_o 1 cycle later. With a write pending, tx_valid_o follows 1 cycle after the grant.
- rx_valid_i coincident with a timeout expiry: the byte wins and the counter resets.
- rx_valid_i during RESP is ignored.

## Test plan
- Frame A5, addr 0x00000100, LEN=2, words 0x11223344 and 0xDEADBEEF, correct CSUM, mem_gnt_i tied 1 -> writes (0x100, 0x11223344) and (0x104, 0xDEADBEEF), then tx byte 0x06.
- Same frame with CSUM^0x01 -> both writes issued, response 0x15.
- addr 0x00000102 -> no mem_req_o at all, response 0x15. LEN=0 -> no writes, response 0x15.
- mem_gnt_i held low 20 cycles while bytes stream at 1 per 4 cycles -> second word dropped, no further writes, response 0x15. Bytes every 40 cycles -> all writes, 0x06.
- Stop mid-DATA with TIMEOUT_CYC=50 -> NAK 0x15 after 50 idle cycles. Deassert dl_en_i mid-frame -> no response; halt_req_o low within 3 cycles after the pending grant.
- Assert rst_ni low mid-DATA with mem_req_o high -> all outputs at reset values immediately. A subsequent valid frame gives 0x06.
